// File: rtl/ctl_pkg.sv
// rtl/ctl_pkg.sv - shared encodings for the ktc32 multicycle controller
//
// Purpose: opcode, ALU-operation, operand-B-select and FSM state encodings
//          shared by controller and aludec.
// Ports:   none (package).
package ctl_pkg;

  // Opcodes (instr[5:0]); bit 0 set marks a 32-bit instruction with immediate
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h03;
  localparam logic [5:0] OP_SUB  = 6'h04;
  localparam logic [5:0] OP_JMP  = 6'h05;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_OR   = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_SLT  = 6'h0C;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h12;
  localparam logic [5:0] OP_HALT = 6'h3E;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operand B select
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_INC  = 2'b01;
  localparam logic [1:0] SRCB_ZERO = 2'b10;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  // FSM states
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_EXEC_R  = 4'd2;
  localparam logic [3:0] ST_EXEC_I  = 4'd3;
  localparam logic [3:0] ST_ALUWB   = 4'd4;
  localparam logic [3:0] ST_MEMADDR = 4'd5;
  localparam logic [3:0] ST_MEMRD   = 4'd6;
  localparam logic [3:0] ST_MEMWB   = 4'd7;
  localparam logic [3:0] ST_MEMWR   = 4'd8;
  localparam logic [3:0] ST_BRANCH  = 4'd9;
  localparam logic [3:0] ST_JUMP    = 4'd10;
  localparam logic [3:0] ST_HALT    = 4'd11;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/controller_if.sv
// rtl/controller_if.sv - memory request/ready handshake between controller and memory
//
// Purpose: bundles the instruction/data memory strobes and the ready return.
// Signals: memread, memwrite (controller -> memory), mem_ready (memory -> controller).
// Modports: master = controller side, slave = memory side.
interface controller_if;
  logic memread;
  logic memwrite;
  logic mem_ready;

  modport master (output memread, output memwrite, input mem_ready);
  modport slave  (input memread, input memwrite, output mem_ready);
endinterface

// File: rtl/aludec.sv
// rtl/aludec.sv - opcode to ALU operation decoder for execute states
//
// Purpose: combinational map of R-type and immediate opcodes to alucontrol.
// Ports:   opcode in 6 - latched instruction opcode
//          alucontrol out 3 - ALU operation; ADD for anything not listed
module aludec
  import ctl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (opcode)
      OP_SUB:        alucontrol = ALU_SUB;
      OP_AND:        alucontrol = ALU_AND;
      OP_OR, OP_ORI: alucontrol = ALU_OR;
      OP_XOR:        alucontrol = ALU_XOR;
      OP_SLT:        alucontrol = ALU_SLT;
      default:       alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - Moore FSM control unit for the ktc32 16-bit multicycle datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback and drives all
//          datapath selects and enables; stalls fetch and load/store on mem_ready.
// Ports:   clk, reset (sync, active-high)
//          opcode in 6, zero in 1
//          mem (controller_if.master): memread, memwrite out; mem_ready in
//          pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc out 1
//          alusrcb out 2, alucontrol out 3, halted out 1, illegal out 1
module controller
  import ctl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              zero,
  controller_if.master      mem,
  output logic              pcen,
  output logic              iord,
  output logic              irwrite,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              alusrca,
  output logic              pcsrc,
  output logic [1:0]        alusrcb,
  output logic [2:0]        alucontrol,
  output logic              halted,
  output logic              illegal
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [2:0] alu_dec;
  logic       memread_c;
  logic       memwrite_c;

  aludec u_aludec (
    .opcode     (opcode),
    .alucontrol (alu_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    pcen       = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    pcsrc      = 1'b0;
    alusrcb    = SRCB_B;
    alucontrol = ALU_ADD;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        memread_c = 1'b1;
        alusrcb   = SRCB_INC;
        // IR and PC capture in the ready cycle itself: the 2/4 increment
        // is chosen from the live instruction word on the memory bus.
        if (mem.mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_rtype(opcode)) begin
          state_d = ST_EXEC_R;
        end else begin
          case (opcode)
            OP_ADDI, OP_ORI: state_d = ST_EXEC_I;
            OP_LD, OP_ST:    state_d = ST_MEMADDR;
            OP_BEQ:          state_d = ST_BRANCH;
            OP_JMP:          state_d = ST_JUMP;
            OP_NOP:          state_d = ST_FETCH;
            OP_HALT:         state_d = ST_HALT;
            default: begin
              illegal = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
      end
      ST_EXEC_R: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        alucontrol = alu_dec;
        state_d    = ST_ALUWB;
      end
      ST_EXEC_I: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = alu_dec;
        state_d    = ST_ALUWB;
      end
      ST_ALUWB: begin
        regwrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEMADDR: begin
        // A + 0: the address is register A unmodified
        alusrca = 1'b1;
        alusrcb = SRCB_ZERO;
        state_d = (opcode == OP_ST) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord      = 1'b1;
        memread_c = 1'b1;
        // The data register is free-running, so MEMWB must be the very
        // next cycle after the ready beat.
        if (mem.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        if (mem.mem_ready) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        alucontrol = ALU_SUB;
        pcsrc      = 1'b1;
        pcen       = zero;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        pcen    = 1'b1;
        pcsrc   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset silences every output immediately, so an in-flight access is
    // dropped in the same cycle reset is seen.
    if (reset) begin
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      pcen       = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      pcsrc      = 1'b0;
      alusrcb    = SRCB_B;
      alucontrol = ALU_ADD;
      halted     = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign mem.memread  = memread_c;
  assign mem.memwrite = memwrite_c;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - self-checking bench for the ktc32 controller
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       halted, illegal;

  controller_if mif ();

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif),
    .pcen       (pcen),
    .iord       (iord),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .pcsrc      (pcsrc),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {memread,memwrite,pcen,iord,irwrite,memtoreg,regwrite,alusrca,pcsrc,alusrcb,alucontrol,halted,illegal}
  logic [15:0] obs;
  assign obs = {mif.memread, mif.memwrite, pcen, iord, irwrite, memtoreg, regwrite,
                alusrca, pcsrc, alusrcb, alucontrol, halted, illegal};

  logic [15:0] sb_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] mk(input logic mr, input logic mw, input logic pe,
                                     input logic io, input logic irw, input logic m2r,
                                     input logic rw, input logic asa, input logic pcs,
                                     input logic [1:0] asb, input logic [2:0] alu,
                                     input logic hlt, input logic ill);
    return {mr, mw, pe, io, irw, m2r, rw, asa, pcs, asb, alu, hlt, ill};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic rdy, input logic z, input logic [15:0] exp_v);
    logic [15:0] e;
    @(negedge clk);
    reset         = rst;
    opcode        = op;
    mif.mem_ready = rdy;
    zero          = z;
    sb_q.push_back(exp_v);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    checks++;
    assert (!(mif.memread && mif.memwrite) && !(regwrite && pcen)) else begin
      errors++;
      $error("FAIL %s_excl obs=%h exp=no_overlap", tag, obs);
    end
  endtask

  logic [15:0] f_rdy, f_wt, dec, ill, wb, ma, mrd, mwb, mwr, br1, br0, jmp, hlt;
  logic [5:0]  rops[6];
  logic [2:0]  ralu[6];

  initial begin
    f_rdy = mk(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0,0);
    f_wt  = mk(1,0,0,0,0,0,0,0,0,2'b01,3'b000,0,0);
    dec   = 16'h0000;
    ill   = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,0,1);
    wb    = mk(0,0,0,0,0,0,1,0,0,2'b00,3'b000,0,0);
    ma    = mk(0,0,0,0,0,0,0,1,0,2'b10,3'b000,0,0);
    mrd   = mk(1,0,0,1,0,0,0,0,0,2'b00,3'b000,0,0);
    mwb   = mk(0,0,0,0,0,1,1,0,0,2'b00,3'b000,0,0);
    mwr   = mk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,0,0);
    br1   = mk(0,0,1,0,0,0,0,1,1,2'b00,3'b001,0,0);
    br0   = mk(0,0,0,0,0,0,0,1,1,2'b00,3'b001,0,0);
    jmp   = mk(0,0,1,0,0,0,0,0,1,2'b00,3'b000,0,0);
    hlt   = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,1,0);
    rops  = '{6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C};
    ralu  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

    reset = 1'b1; opcode = 6'h00; zero = 1'b0; mif.mem_ready = 1'b0;

    // Reset: all outputs low even with mem_ready high
    step("rst0", 1, 6'h00, 1, 0, 16'h0000);
    step("rst1", 1, 6'h00, 1, 0, 16'h0000);

    // R-type: FETCH, DECODE (mem_ready ignored), EXEC_R, ALUWB
    for (int i = 0; i < 6; i++) begin
      step("r_fetch", 0, rops[i], 1, 0, f_rdy);
      step("r_dec",   0, rops[i], 0, 0, dec);
      step("r_exec",  0, rops[i], 1, 0, mk(0,0,0,0,0,0,0,1,0,2'b00,ralu[i],0,0));
      step("r_wb",    0, rops[i], 0, 0, wb);
    end

    // Immediates
    step("addi_f", 0, 6'h01, 1, 0, f_rdy);
    step("addi_d", 0, 6'h01, 1, 0, dec);
    step("addi_x", 0, 6'h01, 1, 0, mk(0,0,0,0,0,0,0,1,0,2'b11,3'b000,0,0));
    step("addi_w", 0, 6'h01, 1, 0, wb);
    step("ori_f",  0, 6'h09, 1, 0, f_rdy);
    step("ori_d",  0, 6'h09, 1, 0, dec);
    step("ori_x",  0, 6'h09, 1, 0, mk(0,0,0,0,0,0,0,1,0,2'b11,3'b011,0,0));
    step("ori_w",  0, 6'h09, 1, 0, wb);

    // NOP with two fetch wait cycles
    step("nop_w0", 0, 6'h00, 0, 0, f_wt);
    step("nop_w1", 0, 6'h00, 0, 1, f_wt);
    step("nop_f",  0, 6'h00, 1, 0, f_rdy);
    step("nop_d",  0, 6'h00, 1, 0, dec);

    // LD with 3 wait cycles in MEMRD: 8 cycles total
    step("ld_f",   0, 6'h10, 1, 0, f_rdy);
    step("ld_d",   0, 6'h10, 1, 0, dec);
    step("ld_ma",  0, 6'h10, 0, 0, ma);
    step("ld_rd0", 0, 6'h10, 0, 0, mrd);
    step("ld_rd1", 0, 6'h10, 0, 0, mrd);
    step("ld_rd2", 0, 6'h10, 0, 0, mrd);
    step("ld_rd3", 0, 6'h10, 1, 0, mrd);
    step("ld_wb",  0, 6'h10, 0, 0, mwb);

    // ST with one wait cycle
    step("st_f",   0, 6'h12, 1, 0, f_rdy);
    step("st_d",   0, 6'h12, 1, 0, dec);
    step("st_ma",  0, 6'h12, 1, 0, ma);
    step("st_wr0", 0, 6'h12, 0, 0, mwr);
    step("st_wr1", 0, 6'h12, 1, 0, mwr);

    // BEQ taken / not taken
    step("beq1_f", 0, 6'h03, 1, 0, f_rdy);
    step("beq1_d", 0, 6'h03, 1, 0, dec);
    step("beq1_b", 0, 6'h03, 1, 1, br1);
    step("beq0_f", 0, 6'h03, 1, 1, f_rdy);
    step("beq0_d", 0, 6'h03, 1, 1, dec);
    step("beq0_b", 0, 6'h03, 1, 0, br0);

    // JMP
    step("jmp_f",  0, 6'h05, 1, 0, f_rdy);
    step("jmp_d",  0, 6'h05, 1, 0, dec);
    step("jmp_j",  0, 6'h05, 1, 0, jmp);

    // Undefined opcode: illegal pulse in DECODE, back to FETCH
    step("ill_f",  0, 6'h2A, 1, 0, f_rdy);
    step("ill_d",  0, 6'h2A, 1, 0, ill);
    step("ill_nf", 0, 6'h00, 1, 0, f_rdy);
    step("ill_nd", 0, 6'h00, 1, 0, dec);

    // Reset during a MEMWR wait abandons the store
    step("stx_f",  0, 6'h12, 1, 0, f_rdy);
    step("stx_d",  0, 6'h12, 1, 0, dec);
    step("stx_ma", 0, 6'h12, 1, 0, ma);
    step("stx_w0", 0, 6'h12, 0, 0, mwr);
    step("stx_w1", 0, 6'h12, 0, 0, mwr);
    step("stx_rs", 1, 6'h12, 1, 0, 16'h0000);
    step("stx_f0", 0, 6'h00, 0, 0, f_wt);
    step("stx_f1", 0, 6'h00, 1, 0, f_rdy);
    step("stx_d1", 0, 6'h00, 1, 0, dec);

    // HALT holds for 20+ cycles regardless of mem_ready/zero
    step("hlt_f",  0, 6'h3E, 1, 0, f_rdy);
    step("hlt_d",  0, 6'h3E, 1, 0, dec);
    for (int i = 0; i < 22; i++) begin
      step("hlt_h", 0, 6'h3E, i[0], i[1], hlt);
    end
    step("hlt_rs", 1, 6'h3E, 1, 0, 16'h0000);
    step("hlt_f0", 0, 6'h00, 0, 0, f_wt);
    step("hlt_f1", 0, 6'h00, 1, 0, f_rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
